// File: rtl/sram_1r1w_init_if.sv
// Request/response bundle for the 1R1W initialising SRAM: one masked write
// port, one read port with a valid-qualified result, and the init status flag.
interface sram_1r1w_init_if #(
  parameter int ADDR_W = 9,
  parameter int WIDTH  = 64,
  parameter int MASK_W = 8
);
  logic              W0_en;
  logic [ADDR_W-1:0] W0_addr;
  logic [WIDTH-1:0]  W0_data;
  logic [MASK_W-1:0] W0_mask;
  logic              R0_en;
  logic [ADDR_W-1:0] R0_addr;
  logic [WIDTH-1:0]  R0_data;
  logic              R0_valid;
  logic              init_done;

  modport master (
    output W0_en, W0_addr, W0_data, W0_mask, R0_en, R0_addr,
    input  R0_data, R0_valid, init_done
  );

  modport slave (
    input  W0_en, W0_addr, W0_data, W0_mask, R0_en, R0_addr,
    output R0_data, R0_valid, init_done
  );
endinterface

// File: rtl/sram_1r1w_init.sv
// Behavioural 1R1W SRAM with lane write masks, 1- or 2-cycle read latency,
// optional same-cycle write-to-read bypass and a zero-fill sequencer after reset.
module sram_1r1w_init #(
  parameter int DEPTH     = 512,
  parameter int WIDTH     = 64,
  parameter int MASK_GRAN = 8,
  parameter int READ_LAT  = 1,
  parameter int BYPASS    = 1,
  localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int MASK_W   = WIDTH / MASK_GRAN
) (
  input logic             clock,
  input logic             reset,
  sram_1r1w_init_if.slave bus
);

  if ((WIDTH % MASK_GRAN) != 0) begin : g_bad_mask_gran
    $error("sram_1r1w_init: WIDTH must be a multiple of MASK_GRAN");
  end
  if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_bad_read_lat
    $error("sram_1r1w_init: READ_LAT must be 1 or 2");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("sram_1r1w_init: DEPTH must be at least 2");
  end

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // One extra bit so out-of-range addresses compare correctly for any DEPTH.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              w_in_range_s;
  logic              r_in_range_s;
  logic              rd_fire_s;
  logic              bypass_hit_s;
  logic [WIDTH-1:0]  wr_bits_s;
  logic [WIDTH-1:0]  rd_word_s;

  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [WIDTH-1:0]  mem_wdata_s;
  logic [WIDTH-1:0]  mem_wbits_s;

  logic              s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]  s1_data_q, s1_data_d;

  assign w_in_range_s = ({1'b0, bus.W0_addr} < DEPTH_EXT);
  assign r_in_range_s = ({1'b0, bus.R0_addr} < DEPTH_EXT);

  // Expand the lane mask to a per-bit write enable.
  always_comb begin
    wr_bits_s = '0;
    for (int i = 0; i < MASK_W; i++) begin
      wr_bits_s[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{bus.W0_mask[i]}};
    end
  end

  // Sequencer: zero-fill every entry in INIT, then steer user writes in READY.
  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = clr_q;
    mem_wdata_s = '0;
    mem_wbits_s = '1;
    case (state_q)
      ST_INIT: begin
        mem_we_s = 1'b1;
        if (clr_q == CLR_LAST) begin
          state_d = ST_READY;
          clr_d   = '0;
        end else begin
          clr_d = clr_q + ADDR_W'(1);
        end
      end
      ST_READY: begin
        if (bus.W0_en && w_in_range_s) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = bus.W0_addr;
          mem_wdata_s = bus.W0_data;
          mem_wbits_s = wr_bits_s;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        clr_d   = '0;
      end
    endcase
  end

  // Sequencer state and clear counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // Storage array; contents are defined by the clear sequence, not by reset.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= (mem_q[mem_waddr_s] & ~mem_wbits_s) | (mem_wdata_s & mem_wbits_s);
    end
  end

  // Read sample, with per-lane forwarding of a same-address write when enabled.
  always_comb begin
    rd_fire_s    = (state_q == ST_READY) && bus.R0_en;
    bypass_hit_s = (BYPASS != 0) && bus.W0_en && w_in_range_s && (bus.W0_addr == bus.R0_addr);
    if (r_in_range_s) begin
      rd_word_s = mem_q[bus.R0_addr];
    end else begin
      rd_word_s = '0;
    end
    if (bypass_hit_s) begin
      rd_word_s = (rd_word_s & ~wr_bits_s) | (bus.W0_data & wr_bits_s);
    end else begin
      rd_word_s = rd_word_s;
    end
    s1_valid_d = rd_fire_s;
    s1_data_d  = rd_fire_s ? rd_word_s : s1_data_q;
  end

  // First read stage: holds the last result between reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;

    // Second stage is a plain retiming register of the sampled result.
    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
    end

    // Second read stage register.
    always_ff @(posedge clock) begin
      if (reset) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_data_q  <= s2_data_d;
      end
    end

    assign bus.R0_valid = s2_valid_q;
    assign bus.R0_data  = s2_data_q;
  end else begin : g_lat1
    assign bus.R0_valid = s1_valid_q;
    assign bus.R0_data  = s1_data_q;
  end

  assign bus.init_done = (state_q == ST_READY);

endmodule

// File: doc/sram_1r1w_init.md
# sram_1r1w_init

Parametrised single-clock 1R1W behavioural SRAM with sub-word write masking, selectable read latency, optional write-to-read bypass and a hardware clear sequencer. It is the next-generation replacement for the fixed-geometry cache/scratchpad memory macros. It provides deterministic post-reset contents and defined read data in every cycle. It drops the randomised-garbage model.

## Interface
Parameters:
- DEPTH, 512, number of entries; any value ≥ 2, power of two not required
- WIDTH, 64, bits per entry
- MASK_GRAN, 8, bits per mask lane; WIDTH % MASK_GRAN != 0 is an elaboration error
- READ_LAT, 1, read latency in cycles; 1 or 2, other values are an elaboration error
- BYPASS, 1, 1 = same-cycle same-address read returns newly written data; 0 = returns old data
- Derived: ADDR_W = max(1, clog2(DEPTH)), MASK_W = WIDTH / MASK_GRAN

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- W0_en  in  1  write request
- W0_addr  in  ADDR_W  write address
- W0_data  in  WIDTH  write data
- W0_mask  in  MASK_W  lane i enables bits [i*MASK_GRAN +: MASK_GRAN]
- R0_en  in  1  read request
- R0_addr  in  ADDR_W  read address
- R0_data  out  WIDTH  read data
- R0_valid  out  1  one-cycle pulse marking R0_data as the result of a read
- init_done  out  1  high once clear sequence complete; requests accepted only when high

## Operation
- State machine: INIT → READY.
  - INIT: clear counter `clr` writes all-zero to ram[clr] each cycle and increments.
  - When `clr` == DEPTH-1 and that write completes, go to READY and assert init_done.
- Reset in any state forces INIT with clr = 0.
  - Reset mid-INIT restarts the clear from entry 0.
  - Reset in READY re-clears the whole array and drops any in-flight read; no R0_valid for it.
- INIT: W0_en and R0_en are ignored. No array update other than the clear, no R0_valid.
- READY write: when W0_en = 1 and W0_addr < DEPTH, each lane with mask = 1 is updated; other lanes keep their value. W0_mask = 0 is a no-op.
- READY read: when R0_en = 1, the array is sampled at the clock edge of the request cycle.
  - R0_addr ≥ DEPTH returns all-zero data, still with an R0_valid pulse.
  - W0_addr ≥ DEPTH: the write is dropped silently.
- Read and write to the same address in the same cycle:
  - BYPASS = 1: result = per-lane merge, W0_data where the mask is set, old contents elsewhere.
  - BYPASS = 0: result = old contents.
  - Both cases: the array is updated per mask.
- Writes in cycles after the read sample do not alter an in-flight result (READ_LAT = 2).
- R0_data holds its last value until the next read result. It never carries random or X data after reset.

## Timing
- Reset values: R0_data = 0, R0_valid = 0, init_done = 0, pipeline valid bits = 0.
- Clear duration: the first cycle with reset low is clear entry 0.
  - init_done rises on the edge that completes entry DEPTH-1, i.e. DEPTH cycles after reset deasserts.
  - The first accepted request is in the cycle init_done is sampled high.
- Read latency: R0_en sampled high at edge N.
  - READ_LAT = 1: R0_data and R0_valid are updated at edge N; visible in cycle N+1.
  - READ_LAT = 2: visible in cycle N+2; the second stage is a plain register.
- Throughput: one read and one write per cycle, fully pipelined, no stalls.
- Write visibility: a write at edge N is visible to a read issued in cycle N+1. With BYPASS = 1 it is also visible to a read issued in the same cycle.

## Test plan
- Reset held 3 cycles, then released with DEPTH = 512 → init_done low for exactly 512 cycles. Reads of addresses 0, 255 and 511 then return 0x0 with R0_valid one cycle later.
- Write addr 5, data 0x1122334455667788, mask 0xFF, then write addr 5, data 0xAAAAAAAAAAAAAAAA, mask 0x0F → read addr 5 returns 0x11223344AAAAAAAA.
- Same-cycle write addr 9, data 0xFFFF…FF, mask 0x01, with read addr 9 (prior contents 0):
  - BYPASS = 1 returns 0x00000000000000FF.
  - BYPASS = 0 returns 0x0.
  - A follow-up read returns 0xFF in both builds.
- READ_LAT = 2, back-to-back reads of addrs 1, 2, 3 holding 0x10, 0x20, 0x30 → R0_valid high for 3 consecutive cycles starting 2 cycles after the first request, with data 0x10, 0x20, 0x30.
- DEPTH = 384: write addr 400 then read addr 400 → read returns 0, and entry 400 mod 384 = 16 is unchanged.
- Reset asserted mid-INIT at clr = 100, then in READY after writing 0xDEAD to addr 7 → each time init_done stays low a full DEPTH cycles, and addr 7 then reads 0.
